// File: rtl/movegen_cell.sv
// Per-square move generator cell: drives the piece's rays, passes them through empty squares,
// detects move classes landing here, and queues one record per class for the move arbiter.
module movegen_cell #(
  parameter int RANK      = 1,
  parameter int FILE      = 1,
  parameter int NRANKS    = 8,
  parameter int NFILES    = 8,
  parameter int KING_FILE = 5,
  parameter int IDX_W     = $clog2(NRANKS*NFILES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pos_valid,
  input  logic [3:0]       in_pos_data,
  output logic [3:0]       out_pos_data,
  input  logic             wtp,
  input  logic [3:0]       i_castle_rights,
  input  logic             emit_move,
  input  logic             i_capture,
  output logic [3:0]       o_pawn,
  input  logic [5:0]       i_pawn,
  output logic [7:0]       o_king,
  input  logic [7:0]       i_king,
  output logic [7:0]       o_slide,
  input  logic [7:0]       i_slide,
  output logic [7:0]       o_knight,
  input  logic [7:0]       i_knight,
  output logic [1:0]       o_castle,
  input  logic [1:0]       i_castle,
  output logic             o_req,
  input  logic             i_gnt,
  output logic [IDX_W-1:0] o_target,
  output logic [2:0]       o_kind,
  output logic             o_promo
);

  localparam bit DBL_N    = (RANK == 3);
  localparam bit DBL_S    = (RANK == NRANKS - 2);
  localparam bit KING_ROW = (RANK == 1) || (RANK == NRANKS);
  localparam bit HOME     = KING_ROW && (FILE == KING_FILE);
  localparam bit CAS_E    = (FILE == KING_FILE + 2);
  localparam bit CAS_W    = (FILE == KING_FILE - 2);
  localparam bit PROMO_W  = (RANK == NRANKS);
  localparam bit PROMO_B  = (RANK == 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t     state;
  logic [3:0] pos;
  logic [5:0] mask;
  logic       wtp_q;

  logic [2:0] ptype;
  logic       empty, opp;
  logic       wp, bp, orth, diag;
  logic [5:0] hits, low, mask_next;
  logic       wtp_next;
  logic [2:0] kind_next;

  assign out_pos_data = pos;
  assign o_target     = IDX_W'((RANK - 1) * NFILES + (FILE - 1));
  assign o_req        = (state == PEND);

  assign ptype = pos[2:0];
  assign empty = (pos == 4'd0);
  assign opp   = !empty && (pos[3] != wtp);

  // Pawns only push forward for their own colour; double push is a pass-through on rank 3 / NRANKS-2.
  assign wp     = emit_move && (pos == 4'hE);
  assign bp     = emit_move && (pos == 4'h6);
  assign o_pawn = {bp, wp, bp | (DBL_S & empty & i_pawn[3]), wp | (DBL_N & empty & i_pawn[0])};

  assign o_king   = {8{emit_move && (ptype == 3'd1)}};
  assign o_knight = {8{emit_move && (ptype == 3'd5)}};

  assign orth    = emit_move && (ptype == 3'd2 || ptype == 3'd3);
  assign diag    = emit_move && (ptype == 3'd2 || ptype == 3'd4);
  assign o_slide = {diag, orth, diag, orth, diag, orth, diag, orth} | ({8{empty}} & i_slide);

  always_comb begin
    o_castle = 2'b00;
    if (HOME) begin
      o_castle = (RANK == 1) ? {i_castle_rights[0], i_castle_rights[1]}
                             : {i_castle_rights[2], i_castle_rights[3]};
    end else if (KING_ROW && empty) begin
      o_castle = i_castle;
    end
  end

  assign hits[0] = empty && (i_pawn[0] || i_pawn[3]);
  assign hits[1] = opp && (i_pawn[1] || i_pawn[2] || i_pawn[4] || i_pawn[5]);
  assign hits[2] = (empty || opp) && (|i_king);
  assign hits[3] = (empty || opp) && (|i_slide);
  assign hits[4] = (empty || opp) && (|i_knight);
  assign hits[5] = empty && ((CAS_E && i_castle[0]) || (CAS_W && i_castle[1]));

  function automatic logic [2:0] first_set(input logic [5:0] m);
    logic [2:0] k;
    k = 3'd0;
    for (int b = 5; b >= 0; b--) begin
      if (m[b]) k = 3'(b);
    end
    return k;
  endfunction

  // Grant retires the current (lowest) class before new hits merge, so a re-hit survives.
  assign low       = mask & (~mask + 6'd1);
  assign mask_next = (mask & ~((o_req && i_gnt) ? low : 6'd0)) | (i_capture ? hits : 6'd0);
  assign wtp_next  = i_capture ? wtp : wtp_q;
  assign kind_next = first_set(mask_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pos     <= 4'd0;
      mask    <= 6'd0;
      wtp_q   <= 1'b0;
      o_kind  <= 3'd0;
      o_promo <= 1'b0;
    end else begin
      if (in_pos_valid) pos <= in_pos_data;
      mask    <= mask_next;
      wtp_q   <= wtp_next;
      state   <= (mask_next != 6'd0) ? PEND : IDLE;
      o_kind  <= kind_next;
      o_promo <= (mask_next != 6'd0) && (kind_next <= 3'd1) &&
                 ((wtp_next && PROMO_W) || (!wtp_next && PROMO_B));
    end
  end

endmodule

// File: tb/tb_movegen_cell.sv
// Bench for movegen_cell: five cells at different squares share one stimulus stream and are
// compared every cycle against a rule-level model, with directed scenarios pinned by literals.
module tb_movegen_cell;

  localparam int N = 5;

  logic       clk;
  logic       rst, in_pos_valid, wtp, emit_move, i_capture, i_gnt;
  logic [3:0] in_pos_data, i_castle_rights;
  logic [5:0] i_pawn;
  logic [7:0] i_king, i_slide, i_knight;
  logic [1:0] i_castle;

  logic [3:0] opd    [N];
  logic [3:0] opawn  [N];
  logic [7:0] oking  [N];
  logic [7:0] oslide [N];
  logic [7:0] oknight[N];
  logic [1:0] ocastle[N];
  logic       oreq   [N];
  logic [5:0] otarget[N];
  logic [2:0] okind  [N];
  logic       opromo [N];

  int nvec = 0;
  int nerr = 0;

  // Model state per cell: board contents, set of pending move classes, wtp seen at last capture.
  int m_pos [N];
  bit pend  [N][6];
  bit m_lw  [N];

  for (genvar g = 0; g < N; g++) begin : gc
    movegen_cell #(
      .RANK((g == 0 || g == 4) ? 8 : (g == 3) ? 3 : 1),
      .FILE((g == 0) ? 1 : (g == 1) ? 7 : (g == 2) ? 6 : 5)
    ) u (
      .clk(clk), .rst(rst), .in_pos_valid(in_pos_valid), .in_pos_data(in_pos_data),
      .out_pos_data(opd[g]), .wtp(wtp), .i_castle_rights(i_castle_rights),
      .emit_move(emit_move), .i_capture(i_capture),
      .o_pawn(opawn[g]), .i_pawn(i_pawn), .o_king(oking[g]), .i_king(i_king),
      .o_slide(oslide[g]), .i_slide(i_slide), .o_knight(oknight[g]), .i_knight(i_knight),
      .o_castle(ocastle[g]), .i_castle(i_castle), .o_req(oreq[g]), .i_gnt(i_gnt),
      .o_target(otarget[g]), .o_kind(okind[g]), .o_promo(opromo[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rk(input int g);
    return (g == 0 || g == 4) ? 8 : (g == 3) ? 3 : 1;
  endfunction

  function automatic int fl(input int g);
    return (g == 0) ? 1 : (g == 1) ? 7 : (g == 2) ? 6 : 5;
  endfunction

  function automatic bit is_empty(input int g);
    return m_pos[g] == 0;
  endfunction

  function automatic bit is_opp(input int g);
    return m_pos[g] != 0 && ((m_pos[g] >= 8) != wtp);
  endfunction

  function automatic logic [3:0] exp_pawn(input int g);
    logic [3:0] r = 4'd0;
    if (emit_move && m_pos[g] == 14) begin r[0] = 1'b1; r[2] = 1'b1; end
    if (emit_move && m_pos[g] == 6)  begin r[1] = 1'b1; r[3] = 1'b1; end
    if (is_empty(g) && rk(g) == 3 && i_pawn[0]) r[0] = 1'b1;
    if (is_empty(g) && rk(g) == 6 && i_pawn[3]) r[1] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] exp_slide(input int g);
    logic [7:0] r;
    int t = m_pos[g] % 8;
    for (int d = 0; d < 8; d++) begin
      bit drives = emit_move && (t == 2 || ((d % 2 == 0) ? t == 3 : t == 4));
      r[d] = drives || (is_empty(g) && i_slide[d]);
    end
    return r;
  endfunction

  function automatic logic [1:0] exp_castle(input int g);
    if (rk(g) != 1 && rk(g) != 8) return 2'b00;
    if (fl(g) == 5) return (rk(g) == 1) ? {i_castle_rights[0], i_castle_rights[1]}
                                        : {i_castle_rights[2], i_castle_rights[3]};
    return is_empty(g) ? i_castle : 2'b00;
  endfunction

  function automatic logic [5:0] exp_hits(input int g);
    logic [5:0] h;
    bit e = is_empty(g);
    bit tgt = e || is_opp(g);
    h[0] = e && (i_pawn[0] || i_pawn[3]);
    h[1] = is_opp(g) && (i_pawn[1] || i_pawn[2] || i_pawn[4] || i_pawn[5]);
    h[2] = tgt && (i_king != 0);
    h[3] = tgt && (i_slide != 0);
    h[4] = tgt && (i_knight != 0);
    h[5] = e && ((fl(g) == 7 && i_castle[0]) || (fl(g) == 3 && i_castle[1]));
    return h;
  endfunction

  function automatic int first_kind(input int g);
    for (int k = 0; k < 6; k++) if (pend[g][k]) return k;
    return -1;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < N; g++) begin
      int  k  = first_kind(g);
      int  t  = m_pos[g] % 8;
      bit  pr = (k == 0 || k == 1) && ((m_lw[g] && rk(g) == 8) || (!m_lw[g] && rk(g) == 1));
      chk("pos",    g, 32'(opd[g]),     32'(m_pos[g]));
      chk("pawn",   g, 32'(opawn[g]),   32'(exp_pawn(g)));
      chk("king",   g, 32'(oking[g]),   (emit_move && t == 1) ? 32'hFF : 32'h0);
      chk("knight", g, 32'(oknight[g]), (emit_move && t == 5) ? 32'hFF : 32'h0);
      chk("slide",  g, 32'(oslide[g]),  32'(exp_slide(g)));
      chk("castle", g, 32'(ocastle[g]), 32'(exp_castle(g)));
      chk("req",    g, 32'(oreq[g]),    32'(k >= 0));
      chk("kind",   g, 32'(okind[g]),   32'((k < 0) ? 0 : k));
      chk("promo",  g, 32'(opromo[g]),  32'(pr));
      chk("target", g, 32'(otarget[g]), 32'((rk(g) - 1) * 8 + (fl(g) - 1)));
    end
  endtask

  task automatic model_edge();
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        m_pos[g] = 0;
        m_lw[g]  = 1'b0;
        for (int k = 0; k < 6; k++) pend[g][k] = 1'b0;
      end else begin
        logic [5:0] h = exp_hits(g);
        int kk = first_kind(g);
        if (in_pos_valid) m_pos[g] = int'(in_pos_data);
        if (i_gnt && kk >= 0) pend[g][kk] = 1'b0;
        if (i_capture) begin
          for (int k = 0; k < 6; k++) if (h[k]) pend[g][k] = 1'b1;
          m_lw[g] = wtp;
        end
      end
    end
  endtask

  // Called one step after a rising edge; checks at the falling edge, then commits the next edge.
  task automatic apply();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_rays();
    i_pawn = '0; i_king = '0; i_slide = '0; i_knight = '0; i_castle = '0;
  endtask

  task automatic load(input logic [3:0] code);
    in_pos_valid = 1'b1; in_pos_data = code;
    apply();
    in_pos_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_pos_valid = 1'b0; in_pos_data = '0; wtp = 1'b0; i_castle_rights = '0;
    emit_move = 1'b0; i_capture = 1'b0; i_gnt = 1'b0;
    clear_rays();
    for (int g = 0; g < N; g++) begin
      m_pos[g] = 0; m_lw[g] = 1'b0;
      for (int k = 0; k < 6; k++) pend[g][k] = 1'b0;
    end
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
    chk("rst_req",   0, 32'(oreq[0]),   32'h0);
    chk("rst_kind",  0, 32'(okind[0]),  32'h0);
    chk("rst_promo", 0, 32'(opromo[0]), 32'h0);
    chk("rst_pos",   0, 32'(opd[0]),    32'h0);

    // White push onto the last rank promotes.
    wtp = 1'b1; i_pawn = 6'b000001; i_capture = 1'b1;
    apply();
    chk("promo_req",    0, 32'(oreq[0]),    32'h1);
    chk("promo_kind",   0, 32'(okind[0]),   32'h0);
    chk("promo_flag",   0, 32'(opromo[0]),  32'h1);
    chk("promo_target", 0, 32'(otarget[0]), 32'd56);
    i_capture = 1'b0; clear_rays(); i_gnt = 1'b1;
    apply();
    chk("promo_drained", 0, 32'(oreq[0]), 32'h0);
    i_gnt = 1'b0;

    // Black knight under white to move: king, slider and knight hits drain in kind order.
    load(4'h5);
    i_slide = 8'b0000_0100; i_knight = 8'b0000_0001; i_king = 8'b0001_0000; i_capture = 1'b1;
    apply();
    chk("multi_req",   0, 32'(oreq[0]),  32'h1);
    chk("multi_kind0", 0, 32'(okind[0]), 32'd2);
    i_capture = 1'b0; clear_rays(); i_gnt = 1'b1;
    apply();
    chk("multi_kind1", 0, 32'(okind[0]), 32'd3);
    apply();
    chk("multi_kind2", 0, 32'(okind[0]), 32'd4);
    apply();
    chk("multi_done", 0, 32'(oreq[0]), 32'h0);
    i_gnt = 1'b0;

    // Slider pass-through, own blocker, opponent capture, then grant and re-hit together.
    load(4'h0);
    i_slide = 8'h01;
    #1;
    chk("slide_pass", 0, 32'(oslide[0]), 32'h01);
    load(4'hB);
    #1;
    chk("slide_block", 0, 32'(oslide[0]), 32'h00);
    i_capture = 1'b1;
    apply();
    chk("slide_own_nohit", 0, 32'(oreq[0]), 32'h0);
    wtp = 1'b0;
    apply();
    chk("slide_opp_req",  0, 32'(oreq[0]),  32'h1);
    chk("slide_opp_kind", 0, 32'(okind[0]), 32'd3);
    i_gnt = 1'b1;
    apply();
    chk("rehit_req",  0, 32'(oreq[0]),  32'h1);
    chk("rehit_kind", 0, 32'(okind[0]), 32'd3);
    i_capture = 1'b0; clear_rays();
    apply();
    chk("rehit_drained", 0, 32'(oreq[0]), 32'h0);
    i_gnt = 1'b0;

    // Castle landing on the king's destination file; the intermediate file forwards or blocks.
    load(4'h0);
    i_castle = 2'b01;
    #1;
    chk("castle_fwd", 2, 32'(ocastle[2]), 32'h1);
    i_capture = 1'b1;
    apply();
    chk("castle_req",  1, 32'(oreq[1]),  32'h1);
    chk("castle_kind", 1, 32'(okind[1]), 32'd5);
    i_capture = 1'b0; i_gnt = 1'b1;
    apply();
    i_gnt = 1'b0;
    load(4'h3);
    #1;
    chk("castle_block", 2, 32'(ocastle[2]), 32'h0);
    clear_rays();

    // Reset mid-pending clears queue and position.
    load(4'h0);
    i_pawn = 6'b000001; i_capture = 1'b1;
    apply();
    chk("pre_rst_req", 0, 32'(oreq[0]), 32'h1);
    i_capture = 1'b0; clear_rays(); rst = 1'b1; i_gnt = 1'b1;
    apply();
    rst = 1'b0; i_gnt = 1'b0;
    chk("mid_rst_req",   0, 32'(oreq[0]),    32'h0);
    chk("mid_rst_pos",   0, 32'(opd[0]),     32'h0);
    chk("mid_rst_slide", 0, 32'(oslide[0]),  32'h0);
    chk("mid_rst_pawn",  0, 32'(opawn[0]),   32'h0);
    chk("mid_rst_cas",   4, 32'(ocastle[4]), 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      int t = $urandom_range(0, 6);
      rst          = ($urandom_range(0, 49) == 0);
      in_pos_valid = ($urandom_range(0, 3) == 0);
      in_pos_data  = (t == 0) ? 4'd0 : {1'($urandom_range(0, 1)), 3'(t)};
      wtp          = 1'($urandom_range(0, 1));
      emit_move    = ($urandom_range(0, 2) == 0);
      i_capture    = ($urandom_range(0, 2) == 0);
      i_gnt        = 1'($urandom_range(0, 1));
      i_castle_rights = 4'($urandom);
      i_pawn   = 6'($urandom) & 6'($urandom);
      i_king   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
      i_slide  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
      i_knight = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
      i_castle = 2'($urandom);
      apply();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
